// File: rtl/cache_replacement_policy.sv
// Per-set victim-way selector for an N-way set-associative cache.
// One recency state vector per set; the victim for line_addr is presented combinationally.
module cache_replacement_policy #(
    parameter int N_WAYS     = 8,
    parameter int LINE_OFF_W = 0,
    parameter int REP_POLICY = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       write_en,
    input  logic [N_WAYS-1:0]                          way_hit,
    input  logic [(LINE_OFF_W > 0 ? LINE_OFF_W : 1)-1:0] line_addr,
    output logic [N_WAYS-1:0]                          way_select,
    output logic [$clog2(N_WAYS)-1:0]                  way_select_bin
);

    localparam int WAY_W  = $clog2(N_WAYS);
    localparam int SET_W  = (LINE_OFF_W > 0) ? LINE_OFF_W : 1;
    localparam int N_SETS = 1 << LINE_OFF_W;

    logic [SET_W-1:0]  set_idx;
    logic [N_WAYS-1:0] victim_oh;
    logic              do_update;

    // write_en is a single-cycle update strobe with no back-pressure; an empty way_hit is a no-op.
    assign do_update = write_en & (|way_hit);

    generate
        if (LINE_OFF_W == 0) begin : g_single_set
            logic unused_addr;
            assign unused_addr = line_addr[0];
            assign set_idx     = 1'b0;
        end else begin : g_multi_set
            assign set_idx = line_addr;
        end
    endgenerate

    generate
        if (REP_POLICY == 1) begin : g_plru_mru
            logic [N_WAYS-1:0] mru [N_SETS];
            logic [N_WAYS-1:0] hit_oh;
            logic [N_WAYS-1:0] mru_cur;
            logic [N_WAYS-1:0] mru_or;
            logic [N_WAYS-1:0] mru_next;
            logic [N_WAYS-1:0] free;

            assign hit_oh   = way_hit & (~way_hit + 1'b1);
            assign mru_cur  = mru[set_idx];
            assign mru_or   = mru_cur | hit_oh;
            assign mru_next = (&mru_or) ? hit_oh : mru_or;
            assign free     = ~mru_cur;
            assign victim_oh = (free == '0) ? N_WAYS'(1) : (free & (~free + 1'b1));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) mru[s] <= '0;
                end else if (do_update) begin
                    mru[set_idx] <= mru_next;
                end
            end
        end else if (REP_POLICY == 2) begin : g_plru_tree
            logic [N_WAYS-2:0] node [N_SETS];
            logic [N_WAYS-2:0] node_cur;
            logic [N_WAYS-2:0] node_next;
            logic [WAY_W-1:0]  hit_idx;
            logic              match;

            assign node_cur = node[set_idx];

            always_comb begin
                hit_idx = '0;
                for (int i = N_WAYS - 1; i >= 0; i--) begin
                    if (way_hit[i]) hit_idx = WAY_W'(i);
                end
            end

            // A leaf is the victim when every node on its path points towards it.
            always_comb begin
                victim_oh = '0;
                match     = 1'b0;
                for (int w = 0; w < N_WAYS; w++) begin
                    match = 1'b1;
                    for (int l = 0; l < WAY_W; l++) begin
                        if (node_cur[(1 << l) - 1 + (w >> (WAY_W - l))] != w[WAY_W-1-l]) match = 1'b0;
                    end
                    victim_oh[w] = match;
                end
            end

            always_comb begin
                node_next = node_cur;
                for (int l = 0; l < WAY_W; l++) begin
                    for (int j = 0; j < (1 << l); j++) begin
                        if ((hit_idx >> (WAY_W - l)) == WAY_W'(j)) begin
                            node_next[(1 << l) - 1 + j] = ~hit_idx[WAY_W-1-l];
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) node[s] <= '0;
                end else if (do_update) begin
                    node[set_idx] <= node_next;
                end
            end
        end else begin : g_lru
            logic [WAY_W-1:0] cnt [N_SETS][N_WAYS];
            logic [WAY_W-1:0] hit_idx;
            logic [WAY_W-1:0] hit_val;
            logic             found;

            always_comb begin
                hit_idx = '0;
                for (int i = N_WAYS - 1; i >= 0; i--) begin
                    if (way_hit[i]) hit_idx = WAY_W'(i);
                end
            end

            assign hit_val = cnt[set_idx][hit_idx];

            always_comb begin
                victim_oh = '0;
                found     = 1'b0;
                for (int i = 0; i < N_WAYS; i++) begin
                    if (!found && cnt[set_idx][i] == '0) begin
                        victim_oh[i] = 1'b1;
                        found        = 1'b1;
                    end
                end
                if (!found) victim_oh[0] = 1'b1;
            end

            // Counters remain a permutation: the hit way becomes MRU, younger ways age by one.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        for (int i = 0; i < N_WAYS; i++) cnt[s][i] <= WAY_W'(i);
                    end
                end else if (do_update) begin
                    for (int i = 0; i < N_WAYS; i++) begin
                        if (WAY_W'(i) == hit_idx) begin
                            cnt[set_idx][i] <= WAY_W'(N_WAYS - 1);
                        end else if (cnt[set_idx][i] > hit_val) begin
                            cnt[set_idx][i] <= cnt[set_idx][i] - 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign way_select = victim_oh;

    always_comb begin
        way_select_bin = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (victim_oh[i]) way_select_bin = way_select_bin | WAY_W'(i);
        end
    end

endmodule

// File: tb/tb_cache_replacement_policy.sv
// Directed bench for cache_replacement_policy: LRU, PLRU-MRU and PLRU-tree single-set
// instances plus a four-set LRU instance, checked against hand-computed victims.
module tb_cache_replacement_policy;

    localparam int N_WAYS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] we;
    logic [7:0] hit [4];
    logic [1:0] addr;
    logic [7:0] sel [4];
    logic [2:0] bin [4];

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];
    int tree_seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    // clock / reset
    always #5 clk = ~clk;

    cache_replacement_policy #(.N_WAYS(N_WAYS), .LINE_OFF_W(0), .REP_POLICY(0)) u_lru (
        .clk(clk), .reset(reset), .write_en(we[0]), .way_hit(hit[0]), .line_addr(1'b0),
        .way_select(sel[0]), .way_select_bin(bin[0])
    );
    cache_replacement_policy #(.N_WAYS(N_WAYS), .LINE_OFF_W(0), .REP_POLICY(1)) u_mru (
        .clk(clk), .reset(reset), .write_en(we[1]), .way_hit(hit[1]), .line_addr(1'b0),
        .way_select(sel[1]), .way_select_bin(bin[1])
    );
    cache_replacement_policy #(.N_WAYS(N_WAYS), .LINE_OFF_W(0), .REP_POLICY(2)) u_tree (
        .clk(clk), .reset(reset), .write_en(we[2]), .way_hit(hit[2]), .line_addr(1'b0),
        .way_select(sel[2]), .way_select_bin(bin[2])
    );
    cache_replacement_policy #(.N_WAYS(N_WAYS), .LINE_OFF_W(2), .REP_POLICY(0)) u_sets (
        .clk(clk), .reset(reset), .write_en(we[3]), .way_hit(hit[3]), .line_addr(addr),
        .way_select(sel[3]), .way_select_bin(bin[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_victim(input int d, input string tag, input int exp_way);
        check({tag, "_oh"}, 32'(sel[d]), 32'(1) << exp_way);
        check({tag, "_bin"}, 32'(bin[d]), 32'(exp_way));
    endtask

    // driver: one-cycle write_en pulse, returns on the following falling edge
    task automatic pulse(input int d, input logic [7:0] h);
        @(negedge clk);
        we[d]  = 1'b1;
        hit[d] = h;
        @(negedge clk);
        we[d]  = 1'b0;
        hit[d] = '0;
    endtask

    // scoreboard-driven miss loop: feed back the current victim as the hit way
    task automatic miss_loop(input int d, input string tag);
        logic [2:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_victim(d, tag, int'(e));
            pulse(d, sel[d]);
        end
    endtask

    initial begin
        reset = 1'b0;
        we    = '0;
        addr  = '0;
        for (int d = 0; d < 4; d++) hit[d] = '0;

        #1;
        for (int d = 0; d < 4; d++) check_victim(d, "rst_hold", 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // multi-set isolation and way_hit corner cases
        addr = 2'd1;
        pulse(3, 8'h01);
        pulse(3, 8'h02);
        check_victim(3, "set1_two_hits", 2);
        addr = 2'd0;
        #1 check_victim(3, "set0_untouched", 0);
        addr = 2'd1;
        pulse(3, 8'h00);
        check_victim(3, "zero_hit", 2);
        pulse(3, 8'h24);
        check_victim(3, "multi_hit_low", 3);
        addr = 2'd0;
        #1 check_victim(3, "set0_still", 0);
        addr = 2'd3;
        pulse(3, 8'h01);
        check_victim(3, "set3_hit0", 1);
        addr = 2'd1;
        #1 check_victim(3, "set1_kept", 3);

        // miss loops per policy
        for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
        miss_loop(0, "lru_miss");
        for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
        miss_loop(1, "mru_miss");
        for (int i = 0; i < 9; i++) exp_q.push_back(3'(tree_seq[i]));
        miss_loop(2, "tree_miss");
        check_victim(0, "lru_after_loop", 1);
        check_victim(1, "mru_after_loop", 1);
        check_victim(2, "tree_after_loop", 4);

        // asynchronous reset mid-run, with a colliding write
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) check_victim(d, "rst_async", 0);
        we[0]  = 1'b1;
        hit[0] = 8'h01;
        @(negedge clk);
        reset  = 1'b1;
        we[0]  = 1'b0;
        hit[0] = '0;
        #1 check_victim(0, "rst_wins", 0);

        // LRU directed hits
        pulse(0, 8'h08);
        check_victim(0, "lru_h3", 0);
        pulse(0, 8'h20);
        check_victim(0, "lru_h5", 0);
        pulse(0, 8'h01);
        check_victim(0, "lru_h0", 1);
        pulse(0, 8'h02);
        check_victim(0, "lru_h1", 2);
        pulse(0, 8'h04);
        check_victim(0, "lru_h2", 4);

        // PLRU-tree: lowest bit of a multi-bit hit is way 2
        pulse(2, 8'h24);
        check_victim(2, "tree_multi_hit", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
